// File: rtl/morse_element_decoder_pkg.sv
// Shared types and defaults for the Morse element decoder and the character lookup stage.
package morse_element_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      GAP   = 2'd2,
      WGAP  = 2'd3
   } state_t;

   localparam logic ELEM_DOT  = 1'b0;
   localparam logic ELEM_DASH = 1'b1;

   localparam int DEF_TICK_DIV     = 50_000_000;
   localparam int DEF_DASH_UNITS   = 2;
   localparam int DEF_LETTER_UNITS = 3;
   localparam int DEF_WORD_UNITS   = 7;
   localparam int DEF_MAX_ELEMS    = 5;
   localparam int DEF_UCNT_W       = 4;
   localparam int LEN_W            = 3;

endpackage

// File: rtl/morse_element_decoder_if.sv
// Key level in, decoded element/letter/space events out.
interface morse_element_decoder_if
   import morse_element_decoder_pkg::*;
#(
   parameter int MAX_ELEMS = DEF_MAX_ELEMS
);
   logic                 dpb;
   logic                 dot_pulse;
   logic                 dash_pulse;
   logic                 sym_valid;
   logic [MAX_ELEMS-1:0] sym_code;
   logic [LEN_W-1:0]     sym_len;
   logic                 sym_ovf;
   logic                 space_valid;

   modport master (
      output dpb,
      input  dot_pulse, dash_pulse, sym_valid, sym_code, sym_len, sym_ovf, space_valid
   );

   modport slave (
      input  dpb,
      output dot_pulse, dash_pulse, sym_valid, sym_code, sym_len, sym_ovf, space_valid
   );
endinterface

// File: rtl/morse_element_decoder_unit_timer.sv
// Prescaler producing one tick per dot length, plus a saturating count of elapsed units.
module morse_element_decoder_unit_timer #(
   parameter int TICK_DIV = 4,
   parameter int UCNT_W   = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr,
   output logic              tick,
   output logic [UCNT_W-1:0] units
);
   localparam int              PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]   PMAX = PW'(TICK_DIV - 1);
   localparam logic [UCNT_W-1:0] USAT = '1;

   logic [PW-1:0] pcnt;

   // tick is left unmasked by clr so the FSM can see an edge and a threshold in the same cycle
   assign tick = (pcnt == PMAX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pcnt  <= '0;
         units <= '0;
      end else if (clr) begin
         pcnt  <= '0;
         units <= '0;
      end else if (tick) begin
         pcnt <= '0;
         if (units != USAT) units <= units + 1'b1;
      end else begin
         pcnt <= pcnt + 1'b1;
      end
   end
endmodule

// File: rtl/morse_element_decoder.sv
// Classifies key presses as dots/dashes, groups them into letters, and flags letter and word gaps.
module morse_element_decoder
   import morse_element_decoder_pkg::*;
#(
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int DASH_UNITS   = DEF_DASH_UNITS,
   parameter int LETTER_UNITS = DEF_LETTER_UNITS,
   parameter int WORD_UNITS   = DEF_WORD_UNITS,
   parameter int MAX_ELEMS    = DEF_MAX_ELEMS,
   parameter int UCNT_W       = DEF_UCNT_W
) (
   input logic                    clk,
   input logic                    reset_n,
   morse_element_decoder_if.slave bus
);
   localparam logic [UCNT_W-1:0] DASH_U      = UCNT_W'(DASH_UNITS);
   localparam logic [UCNT_W-1:0] LETTER_LAST = UCNT_W'(LETTER_UNITS - 1);
   localparam logic [UCNT_W-1:0] WORD_LAST   = UCNT_W'(WORD_UNITS - 1);
   localparam logic [LEN_W-1:0]  LEN_MAX     = LEN_W'(MAX_ELEMS);

   state_t               state, nxt;
   logic                 dpb_q, rise, fall, tick;
   logic                 is_dash, elem_bit;
   logic                 elem_ev, sym_ev, space_ev;
   logic [UCNT_W-1:0]    units;
   logic [MAX_ELEMS-1:0] code_buf, code_out;
   logic [LEN_W-1:0]     len_buf, len_out;
   logic                 ovf_buf, ovf_out;
   logic                 dot_q, dash_q, sym_q, space_q;

   assign rise     = bus.dpb & ~dpb_q;
   assign fall     = ~bus.dpb & dpb_q;
   assign is_dash  = (units >= DASH_U);
   assign elem_bit = is_dash ? ELEM_DASH : ELEM_DOT;

   morse_element_decoder_unit_timer #(
      .TICK_DIV (TICK_DIV),
      .UCNT_W   (UCNT_W)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (rise | fall),
      .tick    (tick),
      .units   (units)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt;
   end

   always_comb begin
      nxt      = state;
      elem_ev  = 1'b0;
      sym_ev   = 1'b0;
      space_ev = 1'b0;
      case (state)
         IDLE:  if (rise) nxt = PRESS;
         PRESS: if (fall) begin
            elem_ev = 1'b1;
            nxt     = GAP;
         end
         // a rise landing on the letter tick still closes the letter first
         GAP: if (tick && units == LETTER_LAST) begin
            sym_ev = 1'b1;
            nxt    = rise ? PRESS : WGAP;
         end else if (rise) begin
            nxt = PRESS;
         end
         WGAP: if (rise) begin
            nxt = PRESS;
         end else if (tick && units == WORD_LAST) begin
            space_ev = 1'b1;
            nxt      = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dpb_q    <= 1'b0;
         dot_q    <= 1'b0;
         dash_q   <= 1'b0;
         sym_q    <= 1'b0;
         space_q  <= 1'b0;
         code_buf <= '0;
         len_buf  <= '0;
         ovf_buf  <= 1'b0;
         code_out <= '0;
         len_out  <= '0;
         ovf_out  <= 1'b0;
      end else begin
         dpb_q   <= bus.dpb;
         dot_q   <= elem_ev & ~is_dash;
         dash_q  <= elem_ev & is_dash;
         sym_q   <= sym_ev;
         space_q <= space_ev;
         if (elem_ev) begin
            if (len_buf < LEN_MAX) begin
               for (int i = 0; i < MAX_ELEMS; i++)
                  if (len_buf == LEN_W'(i)) code_buf[i] <= elem_bit;
               len_buf <= len_buf + 1'b1;
            end else begin
               ovf_buf <= 1'b1;
            end
         end
         if (sym_ev) begin
            code_out <= code_buf;
            len_out  <= len_buf;
            ovf_out  <= ovf_buf;
            code_buf <= '0;
            len_buf  <= '0;
            ovf_buf  <= 1'b0;
         end
      end
   end

   assign bus.dot_pulse   = dot_q;
   assign bus.dash_pulse  = dash_q;
   assign bus.sym_valid   = sym_q;
   assign bus.sym_code    = code_out;
   assign bus.sym_len     = len_out;
   assign bus.sym_ovf     = ovf_out;
   assign bus.space_valid = space_q;
endmodule
